// File: rtl/sound_event_player_if.sv
// Event/audio bundle of the sound player: game events and tick in, tone and status out.
interface sound_event_player_if;
  logic       tick;
  logic       wallHit;
  logic       ballHit;
  logic       pocketHit;
  logic       gameOver;
  logic       audioOut;
  logic       anySound;
  logic       startPulse;
  logic [1:0] soundId;

  modport master (
    output tick, wallHit, ballHit, pocketHit, gameOver,
    input  audioOut, anySound, startPulse, soundId
  );
  modport slave (
    input  tick, wallHit, ballHit, pocketHit, gameOver,
    output audioOut, anySound, startPulse, soundId
  );
endinterface

// File: rtl/sound_event_player.sv
// Turns edge-detected game events into prioritised square-wave tones / short note sequences.
module sound_event_player #(
  parameter int HALF_W = 16,
  parameter int DUR_W  = 8
) (
  input logic                 clk,
  input logic                 resetN,
  sound_event_player_if.slave bus
);
  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state;
  logic [3:0]         evNow, evPrev, rise;
  logic [1:0]         soundId, noteIdx, newId;
  logic [DUR_W-1:0]   durCnt;
  logic [HALF_W-1:0]  halfCnt, halfP;
  logic               audioOut, startPulse;
  logic               hasEv, noteEnd, lastNote, accept;

  // Sound table: half period in clk cycles, duration in ticks, last note index.
  function automatic logic [HALF_W-1:0] halfOf(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b00_00: halfOf = HALF_W'(25000);
      4'b01_00: halfOf = HALF_W'(12500);
      4'b10_00: halfOf = HALF_W'(10000);
      4'b10_01: halfOf = HALF_W'(8000);
      4'b11_00: halfOf = HALF_W'(12500);
      4'b11_01: halfOf = HALF_W'(16666);
      4'b11_10: halfOf = HALF_W'(25000);
      default:  halfOf = HALF_W'(25000);
    endcase
  endfunction

  function automatic logic [DUR_W-1:0] durOf(input logic [1:0] id, input logic [1:0] idx);
    case (id)
      2'd0:    durOf = DUR_W'(30);
      2'd1:    durOf = DUR_W'(50);
      2'd2:    durOf = DUR_W'(100);
      default: durOf = DUR_W'(200);
    endcase
    if (idx > lastOf(id)) durOf = DUR_W'(1);
  endfunction

  function automatic logic [1:0] lastOf(input logic [1:0] id);
    case (id)
      2'd2:    lastOf = 2'd1;
      2'd3:    lastOf = 2'd2;
      default: lastOf = 2'd0;
    endcase
  endfunction

  assign evNow = {bus.gameOver, bus.pocketHit, bus.ballHit, bus.wallHit};
  assign rise  = evNow & ~evPrev;

  always_comb begin
    hasEv = |rise;
    newId = 2'd0;
    if      (rise[3]) newId = 2'd3;
    else if (rise[2]) newId = 2'd2;
    else if (rise[1]) newId = 2'd1;
    halfP    = halfOf(soundId, noteIdx);
    noteEnd  = (state == PLAY) && bus.tick && (durCnt == DUR_W'(1));
    lastNote = (noteIdx == lastOf(soundId));
    // A sequence finishing this very cycle counts as idle for arbitration.
    accept   = hasEv && ((state == IDLE) || (noteEnd && lastNote) || (newId > soundId));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      evPrev     <= '0;
      soundId    <= '0;
      noteIdx    <= '0;
      durCnt     <= '0;
      halfCnt    <= '0;
      audioOut   <= 1'b0;
      startPulse <= 1'b0;
    end else begin
      evPrev     <= evNow;
      startPulse <= 1'b0;
      if (accept) begin
        state      <= PLAY;
        soundId    <= newId;
        noteIdx    <= 2'd0;
        durCnt     <= durOf(newId, 2'd0);
        halfCnt    <= '0;
        audioOut   <= 1'b0;
        startPulse <= 1'b1;
      end else if (state == PLAY) begin
        if (noteEnd) begin
          halfCnt  <= '0;
          audioOut <= 1'b0;
          if (lastNote) begin
            state   <= IDLE;
            noteIdx <= 2'd0;
            durCnt  <= '0;
          end else begin
            noteIdx <= noteIdx + 2'd1;
            durCnt  <= durOf(soundId, noteIdx + 2'd1);
          end
        end else begin
          if (bus.tick) durCnt <= durCnt - DUR_W'(1);
          if (halfCnt == halfP - HALF_W'(1)) begin
            halfCnt  <= '0;
            audioOut <= ~audioOut;
          end else begin
            halfCnt <= halfCnt + HALF_W'(1);
          end
        end
      end
    end
  end

  assign bus.audioOut   = audioOut;
  assign bus.anySound   = (state == PLAY);
  assign bus.startPulse = startPulse;
  assign bus.soundId    = soundId;
endmodule

// File: tb/tb_sound_event_player.sv
// Random and directed stimulus for sound_event_player against a timestamp-based reference model.
module tb_sound_event_player;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  sound_event_player_if bus();
  sound_event_player #(.HALF_W(16), .DUR_W(8)) dut (.clk(clk), .resetN(resetN), .bus(bus));

  int nChk = 0, nPass = 0;
  int HALF [4][3] = '{'{25000, 1, 1}, '{12500, 1, 1}, '{10000, 8000, 1}, '{12500, 16666, 25000}};
  int DUR  [4][3] = '{'{30, 0, 0}, '{50, 0, 0}, '{100, 100, 0}, '{200, 200, 200}};
  int NN   [4]    = '{1, 1, 2, 3};

  // Model: sound is described by its id, current note, ticks left and the cycle the note began.
  int         cyc = 0, mId = 0, mNote = 0, mLeft = 0, mStart = 0, pulses = 0;
  bit         mPlay = 0, mPulse = 0;
  logic [3:0] mPrev = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model();
    logic [3:0] ev, rise;
    int best;
    cyc++;
    ev = {bus.gameOver, bus.pocketHit, bus.ballHit, bus.wallHit};
    rise = ev & ~mPrev;
    mPrev = ev;
    mPulse = 0;
    if (mPlay && bus.tick) begin
      mLeft--;
      if (mLeft == 0) begin
        if (mNote + 1 < NN[mId]) begin
          mNote++;
          mLeft = DUR[mId][mNote];
          mStart = cyc;
        end else mPlay = 0;
      end
    end
    best = -1;
    for (int i = 0; i < 4; i++) if (rise[i]) best = i;
    if (best >= 0 && (!mPlay || best > mId)) begin
      mPlay = 1; mPulse = 1; mId = best; mNote = 0;
      mLeft = DUR[best][0]; mStart = cyc;
    end
  endtask

  function automatic int expAudio();
    return mPlay ? ((cyc - mStart) / HALF[mId][mNote]) % 2 : 0;
  endfunction

  task automatic cyc1();
    @(posedge clk);
    model();
    #1;
    chk("anySound", bus.anySound, mPlay);
    chk("startPulse", bus.startPulse, mPulse);
    chk("audioOut", bus.audioOut, expAudio());
    if (mPlay) chk("soundId", bus.soundId, mId);
    if (bus.startPulse) pulses++;
  endtask

  task automatic setEv(input logic [3:0] e);
    {bus.gameOver, bus.pocketHit, bus.ballHit, bus.wallHit} = e;
  endtask

  task automatic run(input int n, input int every);
    for (int i = 0; i < n; i++) begin
      bus.tick = (every > 0) && ((cyc % every) == 0);
      cyc1();
    end
    bus.tick = 1'b0;
  endtask

  task automatic drainIdle(input string tag);
    int k;
    k = 0;
    while (mPlay && k < 2000) begin
      bus.tick = (cyc % 2 == 0);
      cyc1();
      k++;
    end
    bus.tick = 1'b0;
    chk(tag, bus.anySound, 0);
  endtask

  task automatic resetChecks(input string tag);
    chk({tag, "_any"}, bus.anySound, 0);
    chk({tag, "_audio"}, bus.audioOut, 0);
    chk({tag, "_pulse"}, bus.startPulse, 0);
    chk({tag, "_id"}, bus.soundId, 0);
  endtask

  initial begin
    bit found;
    setEv(4'b0000);
    bus.tick = 1'b0;
    #12;
    resetChecks("rst");
    @(negedge clk) resetN = 1'b1;

    // wall bounce
    setEv(4'b0001); cyc1();
    chk("wall_pulse", bus.startPulse, 1);
    chk("wall_id", bus.soundId, 0);
    setEv(4'b0000); run(100, 3);
    chk("wall_end", bus.anySound, 0);

    // ball and pocket in the same cycle
    pulses = 0;
    setEv(4'b0110); cyc1();
    chk("simul_id", bus.soundId, 2);
    setEv(4'b0000); run(700, 3);
    chk("simul_pulses", pulses, 1);
    chk("simul_end", bus.anySound, 0);

    // preemption and ignored equal/lower events
    setEv(4'b0010); cyc1(); setEv(4'b0000); run(30, 3);
    setEv(4'b0100); cyc1();
    chk("pre_pulse", bus.startPulse, 1);
    chk("pre_id", bus.soundId, 2);
    setEv(4'b0000); run(20, 3);
    setEv(4'b0010); cyc1();
    chk("ign_ball", bus.startPulse, 0);
    setEv(4'b0000); cyc1();
    setEv(4'b0100); cyc1();
    chk("ign_pocket", bus.startPulse, 0);
    chk("ign_id", bus.soundId, 2);
    setEv(4'b0000); drainIdle("pre_end");

    // wall event in the cycle the final note ends
    setEv(4'b0001); cyc1(); setEv(4'b0000);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (mPlay && mNote == NN[mId] - 1 && mLeft == 1) found = 1;
      else begin bus.tick = (cyc % 2 == 0); cyc1(); end
    end
    chk("endEv_reach", found, 1);
    bus.tick = 1'b1; setEv(4'b0001); cyc1();
    chk("endEv_any", bus.anySound, 1);
    chk("endEv_pulse", bus.startPulse, 1);
    bus.tick = 1'b0; setEv(4'b0000); drainIdle("endEv_end");

    // held gameOver level: one sound only
    pulses = 0;
    setEv(4'b1000);
    run(13000, 0);
    run(1300, 2);
    run(500, 0);
    chk("held_pulses", pulses, 1);
    chk("held_end", bus.anySound, 0);
    setEv(4'b0000); cyc1();

    // pocket second note tone
    setEv(4'b0100); cyc1(); setEv(4'b0000);
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (mPlay && mNote == 1) found = 1;
      else begin bus.tick = (cyc % 2 == 0); cyc1(); end
    end
    chk("pocket_note1", found, 1);
    run(16010, 0);
    drainIdle("pocket_end");

    // random events and ticks
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(39) == 0) begin
          case (b)
            0: bus.wallHit   = ~bus.wallHit;
            1: bus.ballHit   = ~bus.ballHit;
            2: bus.pocketHit = ~bus.pocketHit;
            default: bus.gameOver = ~bus.gameOver;
          endcase
        end
      bus.tick = ($urandom_range(2) == 0);
      cyc1();
    end
    setEv(4'b0000); drainIdle("rand_end");

    // reset in the middle of a high audio phase
    setEv(4'b0001); cyc1(); setEv(4'b0000);
    run(30000, 0);
    chk("rst_pre_audio", bus.audioOut, expAudio());
    #2 resetN = 1'b0;
    #1 resetChecks("midrst");
    mPlay = 0; mPulse = 0; mId = 0; mPrev = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) resetN = 1'b1;
    setEv(4'b0001); cyc1();
    chk("post_pulse", bus.startPulse, 1);
    setEv(4'b0000); run(100, 3);
    chk("post_end", bus.anySound, 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
